// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for
// the bit-serial subtractor. The ovf signal exists only when
// SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement a - b - bin, LSB first, one
// full-subtractor step per clock with a registered borrow. Result, borrow-out
// (and signed overflow when SERIAL_SUB_OVF_EN is defined) update only on the
// final step and are held until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             x, y, d, br_nxt;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             done_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    // Full-subtractor cell on the current LSBs and the stored borrow.
    assign x      = a_sh[0];
    assign y      = b_sh[0];
    assign d      = x ^ y ^ br;
    assign br_nxt = (~x & y) | (~(x ^ y) & br);
    assign last   = (cnt == CW'(WIDTH - 1));
    // New difference bit enters at the MSB; after WIDTH steps the word is aligned.
    assign r_nxt  = WIDTH'({d, r_sh} >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: start is only looked at while idle, so requests during SHIFT drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift each SHIFT cycle, publish on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        br   <= bus.bin;
                        r_sh <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff_q <= r_nxt;
                        bout_q <= br_nxt;
                        done_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        // Operand signs differ and result sign differs from a.
                        ovf_q  <= (x ^ y) & (d ^ x);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
